stack_machine_p: RTL and testbench



---
 rtl/stack_machine_p.sv | 234 +++++++++++++++++++++++
 tb/tb_stack_machine_p.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_machine_p.sv
// Byte-opcode stack machine: fetches from a 1-cycle synchronous ROM, executes one opcode per clock.
// Latency: fetch address combinational; write/halted/fault registered, visible one cycle after the executing edge.
// No backpressure: the ROM is always ready and the write strobe is fire-and-forget; halting freezes all state.
module stack_machine_p #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int DSTACK_DEPTH = 8,
  parameter int CSTACK_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] code_addr,
  input  logic [7:0]            code_data,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  halted,
  output logic [2:0]            fault
);

  localparam int DPW = $clog2(DSTACK_DEPTH);
  localparam int CPW = $clog2(CSTACK_DEPTH);
  localparam logic [DPW:0] D_FULL = (DPW+1)'(DSTACK_DEPTH);
  localparam logic [CPW:0] C_FULL = (CPW+1)'(CSTACK_DEPTH);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_STORE = 8'h12;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h21;
  localparam logic [7:0] OP_AND   = 8'h22;
  localparam logic [7:0] OP_OR    = 8'h23;
  localparam logic [7:0] OP_XOR   = 8'h24;
  localparam logic [7:0] OP_DUP   = 8'h25;
  localparam logic [7:0] OP_DROP  = 8'h26;
  localparam logic [7:0] OP_SWAP  = 8'h27;
  localparam logic [7:0] OP_JMP   = 8'h30;
  localparam logic [7:0] OP_JZ    = 8'h31;
  localparam logic [7:0] OP_CALL  = 8'h32;
  localparam logic [7:0] OP_RET   = 8'h33;
  localparam logic [7:0] OP_HALT  = 8'h44;

  // Architectural state
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DPW:0]          r_dcount;
  logic [CPW:0]          r_ccount;
  logic [DATA_WIDTH-1:0] r_dstk [DSTACK_DEPTH];
  logic [ADDR_WIDTH-1:0] r_cstk [CSTACK_DEPTH];
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_halted;
  logic [2:0]            r_fault;

  // Stack views: top-of-stack slot and the two live operands
  logic [DPW-1:0]        w_dtop, w_i0, w_i1;
  logic [CPW-1:0]        w_ctop, w_ci0;
  logic [DATA_WIDTH-1:0] w_s0, w_s1;
  logic [ADDR_WIDTH-1:0] w_c0;

  assign w_dtop = r_dcount[DPW-1:0];
  assign w_i0   = w_dtop - DPW'(1);
  assign w_i1   = w_dtop - DPW'(2);
  assign w_s0   = r_dstk[w_i0];
  assign w_s1   = r_dstk[w_i1];
  assign w_ctop = r_ccount[CPW-1:0];
  assign w_ci0  = w_ctop - CPW'(1);
  assign w_c0   = r_cstk[w_ci0];

  // Decode
  logic [DPW:0]          w_need;
  logic                  w_grow;
  logic                  w_cpop;
  logic                  w_cpush;
  logic                  w_ill;
  logic [2:0]            w_fault_code;
  logic                  w_exec;
  logic                  w_taken;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_imm;

  assign w_imm = {{(DATA_WIDTH-7){code_data[6]}}, code_data[6:0]};

  // Operand requirements and stack growth per opcode
  always_comb begin
    w_need  = '0;
    w_grow  = 1'b0;
    w_cpop  = 1'b0;
    w_cpush = 1'b0;
    w_ill   = 1'b0;
    if (code_data[7]) begin
      w_grow = 1'b1;
    end else begin
      case (code_data)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_need = (DPW+1)'(2);
        OP_DUP:   begin w_need = (DPW+1)'(1); w_grow = 1'b1; end
        OP_DROP:  w_need = (DPW+1)'(1);
        OP_SWAP:  w_need = (DPW+1)'(2);
        OP_STORE: w_need = (DPW+1)'(2);
        OP_JMP:   w_need = (DPW+1)'(1);
        OP_JZ:    w_need = (DPW+1)'(2);
        OP_CALL:  begin w_need = (DPW+1)'(1); w_cpush = 1'b1; end
        OP_RET:   w_cpop = 1'b1;
        OP_NOP, OP_HALT: ;
        default:  w_ill = 1'b1;
      endcase
    end
  end

  // Fault priority: illegal, dstack underflow, dstack overflow, cstack underflow, cstack overflow
  always_comb begin
    w_fault_code = 3'd0;
    if (w_ill)                              w_fault_code = 3'd5;
    else if (r_dcount < w_need)             w_fault_code = 3'd1;
    else if (w_grow && r_dcount == D_FULL)  w_fault_code = 3'd2;
    else if (w_cpop && r_ccount == '0)      w_fault_code = 3'd3;
    else if (w_cpush && r_ccount == C_FULL) w_fault_code = 3'd4;
  end

  assign w_exec = !reset && !r_halted && (w_fault_code == 3'd0);

  // Branch resolution for the opcode currently on code_data
  always_comb begin
    w_taken  = 1'b0;
    w_target = ADDR_WIDTH'(w_s0);
    if (code_data == OP_RET) w_target = w_c0;
    if (w_exec) begin
      case (code_data)
        OP_JMP, OP_CALL, OP_RET: w_taken = 1'b1;
        OP_JZ:                   w_taken = (w_s1 == '0);
        default:                 w_taken = 1'b0;
      endcase
    end
  end

  // Fetch address: redirect on a taken branch so the target executes next edge
  always_comb begin
    code_addr = r_pc;
    if (reset)        code_addr = '0;
    else if (w_taken) code_addr = w_target;
  end

  assign w_next_pc = code_addr + ADDR_WIDTH'(1);

  // ALU result, S1 op S0
  always_comb begin
    case (code_data[2:0])
      3'd0:    w_alu = w_s1 + w_s0;
      3'd1:    w_alu = w_s1 - w_s0;
      3'd2:    w_alu = w_s1 & w_s0;
      3'd3:    w_alu = w_s1 | w_s0;
      3'd4:    w_alu = w_s1 ^ w_s0;
      default: w_alu = '0;
    endcase
  end

  // Control state, stack pointers, write port and sticky status
  always_ff @(posedge clock) begin
    if (reset) begin
      // The ROM latches address 0 on the reset edge itself, so the next fetch is address 1
      r_pc      <= ADDR_WIDTH'(1);
      r_dcount  <= '0;
      r_ccount  <= '0;
      r_write   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_halted  <= 1'b0;
      r_fault   <= 3'd0;
    end else begin
      r_write <= 1'b0;
      if (!r_halted) begin
        r_pc <= w_next_pc;
        if (w_fault_code != 3'd0) begin
          r_fault  <= w_fault_code;
          r_halted <= 1'b1;
        end else if (code_data[7]) begin
          r_dcount <= r_dcount + (DPW+1)'(1);
        end else begin
          case (code_data)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DROP, OP_JMP:
              r_dcount <= r_dcount - (DPW+1)'(1);
            OP_DUP:
              r_dcount <= r_dcount + (DPW+1)'(1);
            OP_STORE: begin
              r_dcount  <= r_dcount - (DPW+1)'(2);
              r_wr_addr <= w_s0;
              r_wr_data <= w_s1;
              r_write   <= 1'b1;
            end
            OP_JZ:
              r_dcount <= r_dcount - (DPW+1)'(2);
            OP_CALL: begin
              r_dcount <= r_dcount - (DPW+1)'(1);
              r_ccount <= r_ccount + (CPW+1)'(1);
            end
            OP_RET:
              r_ccount <= r_ccount - (CPW+1)'(1);
            OP_HALT:
              r_halted <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Stack storage; contents survive reset, only the counts are cleared
  always_ff @(posedge clock) begin
    if (w_exec) begin
      if (code_data[7]) begin
        r_dstk[w_dtop] <= w_imm;
      end else begin
        case (code_data)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r_dstk[w_i1] <= w_alu;
          OP_DUP:  r_dstk[w_dtop] <= w_s0;
          OP_SWAP: begin
            r_dstk[w_i0] <= w_s1;
            r_dstk[w_i1] <= w_s0;
          end
          OP_CALL: r_cstk[w_ctop] <= r_pc;
          default: ;
        endcase
      end
    end
  end

  assign write   = r_write;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign halted  = r_halted;
  assign fault   = r_fault;

endmodule

// File: tb/tb_stack_machine_p.sv
// Bench for stack_machine_p: directed programs plus random programs against an ISA-level interpreter.
// Latency: outputs sampled 2 time units after each rising edge.
// No backpressure: ROM model answers every fetch one cycle later.
module tb_stack_machine_p;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int MAXS = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] code_addr;
  logic [7:0]    code_data = 8'h00;
  logic          write;
  logic [DW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          halted;
  logic [2:0]    fault;

  always #5 clock = ~clock;

  stack_machine_p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DSTACK_DEPTH(8), .CSTACK_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .code_addr(code_addr), .code_data(code_data),
    .write(write), .wr_addr(wr_addr), .wr_data(wr_data), .halted(halted), .fault(fault)
  );

  // Synchronous code ROM, one cycle read latency
  logic [7:0] rom [0:4095];
  always @(posedge clock) code_data <= rom[code_addr];

  int checks = 0;
  int errors = 0;
  int nw, fw, fh;
  logic [7:0] prog[$];

  // Expected outputs after edge k, and fetch address visible after edge k
  logic          e_wr  [0:MAXS];
  logic [DW-1:0] e_wa  [0:MAXS];
  logic [DW-1:0] e_wd  [0:MAXS];
  logic          e_h   [0:MAXS];
  logic [2:0]    e_f   [0:MAXS];
  logic [AW-1:0] e_ca  [0:MAXS];
  logic          e_cav [0:MAXS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h44;
    for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
  endtask

  // ISA interpreter: plain stacks as queues, one instruction per step
  task automatic build_model(input int n);
    logic [DW-1:0] ds[$];
    logic [AW-1:0] cs[$];
    logic [AW-1:0] pc, nxt;
    logic          h, wr;
    logic [2:0]    f;
    logic [DW-1:0] wa, wd, a, b;
    logic [7:0]    op;
    int            need, dlt;
    bit            cpop, cpush, ill;
    pc = '0; h = 0; f = 0; wr = 0; wa = '0; wd = '0;
    e_wr[0] = 0; e_wa[0] = '0; e_wd[0] = '0; e_h[0] = 0; e_f[0] = 0;
    for (int s = 1; s <= n + 1; s++) begin
      e_cav[s-1] = !h;
      wr = 0;
      if (!h) begin
        op = rom[pc];
        need = 0; dlt = 0; cpop = 0; cpush = 0; ill = 0;
        if (op >= 8'h80) dlt = 1;
        else if (op >= 8'h20 && op <= 8'h24) begin need = 2; dlt = -1; end
        else if (op == 8'h25) begin need = 1; dlt = 1; end
        else if (op == 8'h26) begin need = 1; dlt = -1; end
        else if (op == 8'h27) need = 2;
        else if (op == 8'h12 || op == 8'h31) begin need = 2; dlt = -2; end
        else if (op == 8'h30) begin need = 1; dlt = -1; end
        else if (op == 8'h32) begin need = 1; dlt = -1; cpush = 1; end
        else if (op == 8'h33) cpop = 1;
        else if (op != 8'h00 && op != 8'h44) ill = 1;
        nxt = pc + 1;
        if (ill)                           f = 5;
        else if (ds.size() < need)         f = 1;
        else if (dlt > 0 && ds.size() == 8) f = 2;
        else if (cpop && cs.size() == 0)   f = 3;
        else if (cpush && cs.size() == 8)  f = 4;
        if (f != 0) h = 1;
        else if (op >= 8'h80) begin
          a = {{9{op[6]}}, op[6:0]};
          ds.push_back(a);
        end else begin
          case (op)
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24: begin
              a = ds.pop_back(); b = ds.pop_back();
              case (op)
                8'h20: ds.push_back(b + a);
                8'h21: ds.push_back(b - a);
                8'h22: ds.push_back(b & a);
                8'h23: ds.push_back(b | a);
                default: ds.push_back(b ^ a);
              endcase
            end
            8'h25: ds.push_back(ds[ds.size()-1]);
            8'h26: a = ds.pop_back();
            8'h27: begin a = ds.pop_back(); b = ds.pop_back(); ds.push_back(a); ds.push_back(b); end
            8'h12: begin a = ds.pop_back(); b = ds.pop_back(); wa = a; wd = b; wr = 1; end
            8'h30: begin a = ds.pop_back(); nxt = a[AW-1:0]; end
            8'h31: begin a = ds.pop_back(); b = ds.pop_back(); if (b == 0) nxt = a[AW-1:0]; end
            8'h32: begin a = ds.pop_back(); cs.push_back(pc + 1); nxt = a[AW-1:0]; end
            8'h33: nxt = cs.pop_back();
            8'h44: h = 1;
            default: ;
          endcase
        end
        pc = nxt;
      end
      e_ca[s-1] = pc;
      if (s <= n) begin
        e_wr[s] = wr; e_wa[s] = wa; e_wd[s] = wd; e_h[s] = h; e_f[s] = f;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clock); #2; end
    chk("rst.code_addr", code_addr, 0);
    chk("rst.write", write, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.halted", halted, 0);
    chk("rst.fault", fault, 0);
    reset = 1'b0;
  endtask

  task automatic run_check(input int n, input string nm);
    nw = 0; fw = -1; fh = -1;
    for (int k = 0; k <= n; k++) begin
      if (k == 0) #1;
      else begin @(posedge clock); #2; end
      if (write === 1'b1) begin nw++; if (fw < 0) fw = k; end
      if (halted === 1'b1 && fh < 0) fh = k;
      chk($sformatf("%s.write@%0d", nm, k), write, e_wr[k]);
      chk($sformatf("%s.wr_addr@%0d", nm, k), wr_addr, e_wa[k]);
      chk($sformatf("%s.wr_data@%0d", nm, k), wr_data, e_wd[k]);
      chk($sformatf("%s.halted@%0d", nm, k), halted, e_h[k]);
      chk($sformatf("%s.fault@%0d", nm, k), fault, e_f[k]);
      if (e_cav[k]) chk($sformatf("%s.code_addr@%0d", nm, k), code_addr, e_ca[k]);
    end
  endtask

  function automatic logic [7:0] rnd_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 35) return 8'h80 + 8'($urandom_range(0, 15));
    if (r < 40) return 8'hC0 + 8'($urandom_range(0, 63));
    if (r < 58) return 8'h20 + 8'($urandom_range(0, 7));
    if (r < 66) return 8'h12;
    if (r < 86) return 8'h30 + 8'($urandom_range(0, 3));
    if (r < 93) return 8'h00;
    if (r < 97) return 8'h44;
    return 8'h5A;
  endfunction

  initial begin
    prog = '{8'h85, 8'h83, 8'h21, 8'h8A, 8'h12, 8'h44};
    load_prog(); build_model(8); do_reset(); run_check(8, "store");
    chk("store.nwrites", nw, 1); chk("store.write_edge", fw, 5);
    chk("store.wa", wr_addr, 10); chk("store.wd", wr_data, 2);
    chk("store.halt_edge", fh, 6); chk("store.fault", fault, 0);

    prog = '{8'hFF, 8'h82, 8'h20, 8'h81, 8'h12, 8'h44};
    load_prog(); build_model(8); do_reset(); run_check(8, "neg");
    chk("neg.wa", wr_addr, 1); chk("neg.wd", wr_data, 16'h0001);

    prog = '{8'hFF, 8'h80, 8'h12, 8'h44};
    load_prog(); build_model(6); do_reset(); run_check(6, "sext");
    chk("sext.wd", wr_data, 16'hFFFF); chk("sext.write_edge", fw, 3);

    prog = '{8'h20};
    load_prog(); build_model(4); do_reset(); run_check(4, "dunder");
    chk("dunder.fault", fault, 1); chk("dunder.halt_edge", fh, 1); chk("dunder.nwrites", nw, 0);

    prog = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
    load_prog(); build_model(12); do_reset(); run_check(12, "dover");
    chk("dover.fault", fault, 2); chk("dover.halt_edge", fh, 9);

    prog = '{8'h85, 8'h32, 8'h44, 8'h00, 8'h00, 8'h81, 8'h82, 8'h20, 8'h33};
    load_prog(); build_model(10); do_reset(); run_check(10, "call");
    chk("call.fault", fault, 0); chk("call.halt_edge", fh, 7);

    prog = '{8'h85, 8'h32, 8'h80, 8'h12, 8'h44, 8'h81, 8'h82, 8'h20, 8'h33};
    load_prog(); build_model(11); do_reset(); run_check(11, "calls0");
    chk("calls0.wa", wr_addr, 0); chk("calls0.wd", wr_data, 3); chk("calls0.write_edge", fw, 8);

    prog = '{8'h33};
    load_prog(); build_model(4); do_reset(); run_check(4, "cunder");
    chk("cunder.fault", fault, 3); chk("cunder.halt_edge", fh, 1);

    prog = '{8'h80, 8'h86, 8'h31, 8'h44, 8'h44, 8'h44, 8'h86, 8'h44};
    load_prog(); build_model(8); do_reset(); run_check(8, "jz_taken");
    chk("jz_taken.halt_edge", fh, 5); chk("jz_taken.fault", fault, 0);

    prog = '{8'h81, 8'h86, 8'h31, 8'h44};
    load_prog(); build_model(6); do_reset(); run_check(6, "jz_fall");
    chk("jz_fall.halt_edge", fh, 4);

    prog = '{8'h5A};
    load_prog(); build_model(4); do_reset(); run_check(4, "illegal");
    chk("illegal.fault", fault, 5);

    // Reset pulse landing on the STORE write cycle, then a clean rerun
    prog = '{8'h85, 8'h83, 8'h21, 8'h8A, 8'h12, 8'h44};
    load_prog(); build_model(8); do_reset(); run_check(5, "mid");
    chk("mid.write_before", write, 1);
    reset = 1'b1;
    @(posedge clock); #2;
    chk("mid.rst.write", write, 0); chk("mid.rst.halted", halted, 0);
    chk("mid.rst.fault", fault, 0); chk("mid.rst.code_addr", code_addr, 0);
    chk("mid.rst.wr_addr", wr_addr, 0);
    reset = 1'b0;
    run_check(8, "rerun");
    chk("rerun.write_edge", fw, 5); chk("rerun.wa", wr_addr, 10);

    for (int t = 0; t < 15; t++) begin
      prog.delete();
      for (int i = 0; i < 64; i++) prog.push_back(rnd_op());
      load_prog(); build_model(40); do_reset();
      run_check(40, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
